// File: rtl/chan_pkt_buffer.sv
// Per-channel transmit packet buffer: whole packets are stored in fixed slots, the head packet is shown ahead.
// Latency: a packet becomes visible (o_pkt_waiting) one cycle after its last word is written; reads are combinational.
// Backpressure: o_have_space drops when every slot holds a complete packet; writes made then are dropped and flag o_overrun.
//
// Ports:
//   i_tx_clock    sole clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_wrreq       write strobe for i_wrdata
//   i_wrdata      packet word (0 = header, 1 = timestamp, then payload)
//   i_wr_eop      last word of the packet (qualifies i_wrreq)
//   o_have_space  a free slot exists for writing
//   o_overrun     sticky, a write was dropped for lack of space
//   o_fifodata    word at the current read offset of the head slot
//   o_pkt_waiting at least one complete packet is stored
//   i_rdreq       ack of the current o_fifodata word, advance the read offset
//   i_skip        discard the rest of the head packet and release its slot
//   o_pkt_count   number of complete packets stored
module chan_pkt_buffer #(
   parameter int NUM_PKTS_LOG2   = 2,
   parameter int SLOT_WORDS_LOG2 = 7
) (
   input  logic                     i_tx_clock,
   input  logic                     i_reset,
   input  logic                     i_wrreq,
   input  logic [31:0]              i_wrdata,
   input  logic                     i_wr_eop,
   output logic                     o_have_space,
   output logic                     o_overrun,
   output logic [31:0]              o_fifodata,
   output logic                     o_pkt_waiting,
   input  logic                     i_rdreq,
   input  logic                     i_skip,
   output logic [NUM_PKTS_LOG2:0]   o_pkt_count
);

   localparam int NUM_PKTS = 1 << NUM_PKTS_LOG2;
   localparam int ADDR_W   = NUM_PKTS_LOG2 + SLOT_WORDS_LOG2;
   localparam int DEPTH    = 1 << ADDR_W;

   localparam logic [NUM_PKTS_LOG2:0]     FULL_CNT = (NUM_PKTS_LOG2 + 1)'(NUM_PKTS);
   localparam logic [NUM_PKTS_LOG2:0]     CNT_ONE  = (NUM_PKTS_LOG2 + 1)'(1);
   localparam logic [NUM_PKTS_LOG2-1:0]   SLOT_ONE = NUM_PKTS_LOG2'(1);
   localparam logic [SLOT_WORDS_LOG2-1:0] OFF_ONE  = SLOT_WORDS_LOG2'(1);
   localparam logic [SLOT_WORDS_LOG2-1:0] OFF_MAX  = '1;

   // packet storage, deliberately not reset
   logic [31:0] r_mem [DEPTH];

   logic [NUM_PKTS_LOG2-1:0]   r_wr_slot;
   logic [SLOT_WORDS_LOG2-1:0] r_wr_offset;
   logic [NUM_PKTS_LOG2-1:0]   r_rd_slot;
   logic [SLOT_WORDS_LOG2-1:0] r_rd_offset;
   logic [NUM_PKTS_LOG2:0]     r_pkt_count;
   logic                       r_overrun;

   logic              w_have_space;
   logic              w_pkt_waiting;
   logic              w_wr_accept;
   logic              w_commit;
   logic              w_release;
   logic              w_rd_advance;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;

   assign w_have_space  = (r_pkt_count < FULL_CNT);
   assign w_pkt_waiting = (r_pkt_count != '0);
   assign w_wr_accept   = i_wrreq & w_have_space;
   // a slot that fills up terminates its packet even without eop
   assign w_commit      = w_wr_accept & (i_wr_eop | (r_wr_offset == OFF_MAX));
   assign w_release     = i_skip & w_pkt_waiting;
   // skip has priority; the offset saturates so it never walks into the next slot
   assign w_rd_advance  = ~i_skip & i_rdreq & w_pkt_waiting & (r_rd_offset != OFF_MAX);
   assign w_wr_addr     = {r_wr_slot, r_wr_offset};
   assign w_rd_addr     = {r_rd_slot, r_rd_offset};

   assign o_have_space  = w_have_space;
   assign o_pkt_waiting = w_pkt_waiting;
   assign o_pkt_count   = r_pkt_count;
   assign o_overrun     = r_overrun;
   assign o_fifodata    = r_mem[w_rd_addr];

   always_ff @(posedge i_tx_clock) begin
      if (w_wr_accept) begin
         r_mem[w_wr_addr] <= i_wrdata;
      end
   end

   // write pointer and sticky overrun
   always_ff @(posedge i_tx_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_slot   <= '0;
         r_wr_offset <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (i_wrreq && !w_have_space) begin
            r_overrun <= 1'b1;
         end
         if (w_commit) begin
            r_wr_slot   <= r_wr_slot + SLOT_ONE;
            r_wr_offset <= '0;
         end else if (w_wr_accept) begin
            r_wr_offset <= r_wr_offset + OFF_ONE;
         end
      end
   end

   // read pointer
   always_ff @(posedge i_tx_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_rd_slot   <= '0;
         r_rd_offset <= '0;
      end else begin
         if (w_release) begin
            r_rd_slot   <= r_rd_slot + SLOT_ONE;
            r_rd_offset <= '0;
         end else if (w_rd_advance) begin
            r_rd_offset <= r_rd_offset + OFF_ONE;
         end
      end
   end

   // a commit and a release on the same edge cancel out
   always_ff @(posedge i_tx_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_pkt_count <= '0;
      end else begin
         if (w_commit && !w_release) begin
            r_pkt_count <= r_pkt_count + CNT_ONE;
         end else if (!w_commit && w_release) begin
            r_pkt_count <= r_pkt_count - CNT_ONE;
         end
      end
   end

endmodule
